// File: rtl/nm_mac_pkg.sv
// Shared widths, control-bit indices and product helper for the dual 18x18 MAC.
package nm_mac_pkg;

    localparam int unsigned OPERAND_WIDTH = 18;
    localparam int unsigned PRODUCT_WIDTH = 36;
    localparam int unsigned NUM_STAGES    = 4;

    // clr bit assignment
    localparam int unsigned CLR_WIDTH = 2;
    localparam int unsigned CLR_IN    = 0;
    localparam int unsigned CLR_PIPE  = 1;

    // ena bit assignment
    localparam int unsigned ENA_WIDTH = 3;
    localparam int unsigned ENA_IN    = 0;
    localparam int unsigned ENA_PIPE  = 1;
    localparam int unsigned ENA_OUT   = 2;

    typedef logic [OPERAND_WIDTH-1:0] operand_t;
    typedef logic [PRODUCT_WIDTH-1:0] product_t;

    // Full-width unsigned product of two zero-extended operands.
    function automatic product_t mul_full(input operand_t x, input operand_t y);
        return product_t'(x) * product_t'(y);
    endfunction

endpackage

// File: rtl/nm_mac_lane.sv
// One unsigned multiplier lane with four individually bypassable stages:
// input reg, input-pipeline reg, multiply, second-pipeline reg, output reg.
module nm_mac_lane
    import nm_mac_pkg::*;
#(
    parameter int unsigned X_WIDTH = 18,
    parameter int unsigned Y_WIDTH = 18,
    parameter int unsigned R_WIDTH = 36,
    parameter int unsigned IN_REG  = 1,
    parameter int unsigned IP_REG  = 1,
    parameter int unsigned SP_REG  = 1,
    parameter int unsigned OUT_REG = 1
) (
    input  logic                 clk_i,
    input  logic [CLR_WIDTH-1:0] clr_i,
    input  logic [ENA_WIDTH-1:0] ena_i,
    input  logic [X_WIDTH-1:0]   x_i,
    input  logic [Y_WIDTH-1:0]   y_i,
    output logic [R_WIDTH-1:0]   result_o
);

    if (IN_REG > 1 || IP_REG > 1 || SP_REG > 1 || OUT_REG > 1 ||
        (IN_REG + IP_REG + SP_REG + OUT_REG) > NUM_STAGES) begin : g_bad_stage
        $fatal(1, "nm_mac_lane: stage enables must be 0 or 1");
    end

    operand_t x_ext, y_ext;
    operand_t in_x, in_y;
    operand_t ip_x, ip_y;
    product_t prod, sp_p, out_p;

    assign x_ext = operand_t'(x_i);
    assign y_ext = operand_t'(y_i);

    // Control bits that a bypassed stage leaves unread.
    logic unused_ok;
    assign unused_ok = &{1'b0, clr_i, ena_i};

    if (IN_REG != 0) begin : g_in_reg
        operand_t in_x_q, in_y_q;
        // Input stage: capture operands when enabled, cleared by clr[0].
        always_ff @(posedge clk_i or posedge clr_i[CLR_IN]) begin
            if (clr_i[CLR_IN]) begin
                in_x_q <= '0;
                in_y_q <= '0;
            end else if (ena_i[ENA_IN]) begin
                in_x_q <= x_ext;
                in_y_q <= y_ext;
            end
        end
        assign in_x = in_x_q;
        assign in_y = in_y_q;
    end else begin : g_in_byp
        assign in_x = x_ext;
        assign in_y = y_ext;
    end

    if (IP_REG != 0) begin : g_ip_reg
        operand_t ip_x_q, ip_y_q;
        // Input-pipeline stage: second operand register ahead of the multiplier.
        always_ff @(posedge clk_i or posedge clr_i[CLR_PIPE]) begin
            if (clr_i[CLR_PIPE]) begin
                ip_x_q <= '0;
                ip_y_q <= '0;
            end else if (ena_i[ENA_PIPE]) begin
                ip_x_q <= in_x;
                ip_y_q <= in_y;
            end
        end
        assign ip_x = ip_x_q;
        assign ip_y = ip_y_q;
    end else begin : g_ip_byp
        assign ip_x = in_x;
        assign ip_y = in_y;
    end

    assign prod = mul_full(ip_x, ip_y);

    if (SP_REG != 0) begin : g_sp_reg
        product_t sp_q;
        // Second-pipeline stage: register the raw product.
        always_ff @(posedge clk_i or posedge clr_i[CLR_PIPE]) begin
            if (clr_i[CLR_PIPE]) begin
                sp_q <= '0;
            end else if (ena_i[ENA_PIPE]) begin
                sp_q <= prod;
            end
        end
        assign sp_p = sp_q;
    end else begin : g_sp_byp
        assign sp_p = prod;
    end

    if (OUT_REG != 0) begin : g_out_reg
        product_t out_q;
        // Output stage: final product register on its own enable.
        always_ff @(posedge clk_i or posedge clr_i[CLR_PIPE]) begin
            if (clr_i[CLR_PIPE]) begin
                out_q <= '0;
            end else if (ena_i[ENA_OUT]) begin
                out_q <= sp_p;
            end
        end
        assign out_p = out_q;
    end else begin : g_out_byp
        assign out_p = sp_p;
    end

    assign result_o = out_p[R_WIDTH-1:0];

endmodule

// File: rtl/nm_mac_dual18.sv
// Two independent unsigned 18x18 multiplier lanes sharing clock, clear and enables.
module nm_mac_dual18
    import nm_mac_pkg::*;
#(
    parameter int unsigned AX_WIDTH            = 18,
    parameter int unsigned AY_WIDTH            = 18,
    parameter int unsigned BX_WIDTH            = 18,
    parameter int unsigned BY_WIDTH            = 18,
    parameter int unsigned RESULT_A_WIDTH      = 36,
    parameter int unsigned RESULT_B_WIDTH      = 36,
    parameter int unsigned INPUT_REG           = 1,
    parameter int unsigned INPUT_PIPELINE_REG  = 1,
    parameter int unsigned SECOND_PIPELINE_REG = 1,
    parameter int unsigned OUTPUT_REG          = 1
) (
    input  logic                      clk,
    input  logic [CLR_WIDTH-1:0]      clr,
    input  logic [ENA_WIDTH-1:0]      ena,
    input  logic [AX_WIDTH-1:0]       ax,
    input  logic [AY_WIDTH-1:0]       ay,
    input  logic [BX_WIDTH-1:0]       bx,
    input  logic [BY_WIDTH-1:0]       by,
    output logic [RESULT_A_WIDTH-1:0] resulta,
    output logic [RESULT_B_WIDTH-1:0] resultb
);

    if (AX_WIDTH < 1 || AX_WIDTH > OPERAND_WIDTH) begin : g_bad_ax
        $fatal(1, "nm_mac_dual18: AX_WIDTH out of range 1..18");
    end
    if (AY_WIDTH < 1 || AY_WIDTH > OPERAND_WIDTH) begin : g_bad_ay
        $fatal(1, "nm_mac_dual18: AY_WIDTH out of range 1..18");
    end
    if (BX_WIDTH < 1 || BX_WIDTH > OPERAND_WIDTH) begin : g_bad_bx
        $fatal(1, "nm_mac_dual18: BX_WIDTH out of range 1..18");
    end
    if (BY_WIDTH < 1 || BY_WIDTH > OPERAND_WIDTH) begin : g_bad_by
        $fatal(1, "nm_mac_dual18: BY_WIDTH out of range 1..18");
    end
    if (RESULT_A_WIDTH < 1 || RESULT_A_WIDTH > PRODUCT_WIDTH) begin : g_bad_ra
        $fatal(1, "nm_mac_dual18: RESULT_A_WIDTH out of range 1..36");
    end
    if (RESULT_B_WIDTH < 1 || RESULT_B_WIDTH > PRODUCT_WIDTH) begin : g_bad_rb
        $fatal(1, "nm_mac_dual18: RESULT_B_WIDTH out of range 1..36");
    end

    nm_mac_lane #(
        .X_WIDTH (AX_WIDTH),
        .Y_WIDTH (AY_WIDTH),
        .R_WIDTH (RESULT_A_WIDTH),
        .IN_REG  (INPUT_REG),
        .IP_REG  (INPUT_PIPELINE_REG),
        .SP_REG  (SECOND_PIPELINE_REG),
        .OUT_REG (OUTPUT_REG)
    ) u_lane_a (
        .clk_i    (clk),
        .clr_i    (clr),
        .ena_i    (ena),
        .x_i      (ax),
        .y_i      (ay),
        .result_o (resulta)
    );

    nm_mac_lane #(
        .X_WIDTH (BX_WIDTH),
        .Y_WIDTH (BY_WIDTH),
        .R_WIDTH (RESULT_B_WIDTH),
        .IN_REG  (INPUT_REG),
        .IP_REG  (INPUT_PIPELINE_REG),
        .SP_REG  (SECOND_PIPELINE_REG),
        .OUT_REG (OUTPUT_REG)
    ) u_lane_b (
        .clk_i    (clk),
        .clr_i    (clr),
        .ena_i    (ena),
        .x_i      (bx),
        .y_i      (by),
        .result_o (resultb)
    );

endmodule

// File: tb/tb_nm_mac_dual18.sv
// Bench for nm_mac_dual18: default 4-stage instance plus an output-register-only
// instance with a 16-bit A result, both checked against a behavioural model.
module tb_nm_mac_dual18;

    logic        clk = 1'b0;
    logic [1:0]  clr;
    logic [2:0]  ena;
    logic [17:0] ax, ay, bx, by;
    logic [35:0] ra, rb, rb2;
    logic [15:0] ra2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nm_mac_dual18 u_dut (
        .clk     (clk),
        .clr     (clr),
        .ena     (ena),
        .ax      (ax),
        .ay      (ay),
        .bx      (bx),
        .by      (by),
        .resulta (ra),
        .resultb (rb)
    );

    nm_mac_dual18 #(
        .RESULT_A_WIDTH      (16),
        .INPUT_REG           (0),
        .INPUT_PIPELINE_REG  (0),
        .SECOND_PIPELINE_REG (0),
        .OUTPUT_REG          (1)
    ) u_dut_out (
        .clk     (clk),
        .clr     (clr),
        .ena     (ena),
        .ax      (ax),
        .ay      (ay),
        .bx      (bx),
        .by      (by),
        .resulta (ra2),
        .resultb (rb2)
    );

    // Behavioural model, one entry per lane (0 = A, 1 = B).
    // Four-stage instance: operand pair in stage 1 and 2, product in stage 3 and 4.
    longint unsigned s1x[2], s1y[2], s2x[2], s2y[2], s3p[2], s4p[2];
    // Output-register-only instance: full product held before truncation.
    longint unsigned o2p[2];

    function automatic longint unsigned low_bits(longint unsigned v, int w);
        return v % (64'd1 << w);
    endfunction

    task automatic model_clear();
        for (int l = 0; l < 2; l++) begin
            if (clr[0]) begin
                s1x[l] = 0; s1y[l] = 0;
            end
            if (clr[1]) begin
                s2x[l] = 0; s2y[l] = 0; s3p[l] = 0; s4p[l] = 0; o2p[l] = 0;
            end
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        longint unsigned opx[2], opy[2];
        opx[0] = ax; opy[0] = ay; opx[1] = bx; opy[1] = by;
        for (int l = 0; l < 2; l++) begin
            if (ena[2]) begin
                s4p[l] = s3p[l];
                o2p[l] = opx[l] * opy[l];
            end
            if (ena[1]) begin
                s3p[l] = s2x[l] * s2y[l];
                s2x[l] = s1x[l];
                s2y[l] = s1y[l];
            end
            if (ena[0]) begin
                s1x[l] = opx[l];
                s1y[l] = opy[l];
            end
        end
        model_clear();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_ops(input logic [17:0] a_x, input logic [17:0] a_y,
                           input logic [17:0] b_x, input logic [17:0] b_y);
        ax = a_x; ay = a_y; bx = b_x; by = b_y;
    endtask

    task automatic test_reset();
        clr = 2'b11;
        ena = 3'b000;
        set_ops(0, 0, 0, 0);
        model_clear();
        #2;
        checks++; if (ra !== 36'd0)  begin errors++; $display("FAIL reset_ra: got %0d expected 0", ra); end
        checks++; if (rb !== 36'd0)  begin errors++; $display("FAIL reset_rb: got %0d expected 0", rb); end
        checks++; if (ra2 !== 16'd0) begin errors++; $display("FAIL reset_ra2: got %0d expected 0", ra2); end
        checks++; if (rb2 !== 36'd0) begin errors++; $display("FAIL reset_rb2: got %0d expected 0", rb2); end
        // clear beats enable
        ena = 3'b111;
        set_ops(18'd1000, 18'd1000, 18'd999, 18'd999);
        tick();
        tick();
        checks++; if (ra !== 36'd0)  begin errors++; $display("FAIL reset_prio_ra: got %0d expected 0", ra); end
        checks++; if (ra2 !== 16'd0) begin errors++; $display("FAIL reset_prio_ra2: got %0d expected 0", ra2); end
        set_ops(0, 0, 0, 0);
        clr = 2'b00;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_single();
        ena = 3'b111;
        set_ops(18'd3, 18'd5, 18'd7, 18'd11);
        tick();
        set_ops(0, 0, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            logic [35:0] ea, eb;
            ea = (c == 4) ? 36'd15 : 36'd0;
            eb = (c == 4) ? 36'd77 : 36'd0;
            checks++; if (ra !== ea) begin errors++; $display("FAIL single_ra c%0d: got %0d expected %0d", c, ra, ea); end
            checks++; if (rb !== eb) begin errors++; $display("FAIL single_rb c%0d: got %0d expected %0d", c, rb, eb); end
            tick();
        end
    endtask

    task automatic test_max();
        ena = 3'b111;
        set_ops(18'd262143, 18'd262143, 18'd262143, 18'd262143);
        tick();
        set_ops(0, 0, 0, 0);
        tick(); tick(); tick();
        checks++; if (ra !== 36'hFFFF80001) begin errors++; $display("FAIL max_ra: got %0h expected FFFF80001", ra); end
        checks++; if (rb !== 36'hFFFF80001) begin errors++; $display("FAIL max_rb: got %0h expected FFFF80001", rb); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_back_to_back();
        ena = 3'b111;
        for (int n = 1; n <= 13; n++) begin
            if (n <= 10) set_ops(18'(n), 18'd2, 0, 0);
            else         set_ops(0, 0, 0, 0);
            tick();
            if (n >= 4) begin
                logic [35:0] ea;
                ea = 36'(2 * (n - 3));
                checks++; if (ra !== ea) begin errors++; $display("FAIL b2b_ra n%0d: got %0d expected %0d", n, ra, ea); end
            end
        end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_stall();
        logic [35:0] prev;
        ena = 3'b111;
        for (int n = 0; n < 16; n++) begin
            set_ops(18'(100 + n), 18'd3, 18'(200 + n), 18'd7);
            ena = (n == 6 || n == 7) ? 3'b101 : 3'b111;
            prev = ra;
            tick();
            checks++; if (ra !== 36'(s4p[0])) begin errors++; $display("FAIL stall_ra n%0d: got %0d expected %0d", n, ra, s4p[0]); end
            checks++; if (rb !== 36'(s4p[1])) begin errors++; $display("FAIL stall_rb n%0d: got %0d expected %0d", n, rb, s4p[1]); end
            if (n == 7) begin
                checks++; if (ra !== prev) begin errors++; $display("FAIL stall_hold: got %0d expected %0d", ra, prev); end
            end
        end
    endtask

    task automatic test_clear_mid();
        ena = 3'b111;
        for (int n = 0; n < 5; n++) begin
            set_ops(18'(500 + n), 18'd9, 18'(600 + n), 18'd5);
            tick();
        end
        #2;
        clr = 2'b11;
        model_clear();
        #1;
        checks++; if (ra !== 36'd0)  begin errors++; $display("FAIL clr_async_ra: got %0d expected 0", ra); end
        checks++; if (rb !== 36'd0)  begin errors++; $display("FAIL clr_async_rb: got %0d expected 0", rb); end
        checks++; if (ra2 !== 16'd0) begin errors++; $display("FAIL clr_async_ra2: got %0d expected 0", ra2); end
        tick();
        #2;
        clr = 2'b00;
        set_ops(18'd9, 18'd9, 18'd4, 18'd5);
        tick();
        checks++; if (ra2 !== 16'd81) begin errors++; $display("FAIL clr_resume_ra2: got %0d expected 81", ra2); end
        set_ops(0, 0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            logic [35:0] ea, eb;
            ea = (c == 4) ? 36'd81 : 36'd0;
            eb = (c == 4) ? 36'd20 : 36'd0;
            checks++; if (ra !== ea) begin errors++; $display("FAIL clr_resume_ra c%0d: got %0d expected %0d", c, ra, ea); end
            checks++; if (rb !== eb) begin errors++; $display("FAIL clr_resume_rb c%0d: got %0d expected %0d", c, rb, eb); end
            if (c < 4) tick();
        end
    endtask

    task automatic test_out_only();
        ena = 3'b111;
        set_ops(18'd300, 18'd300, 18'd1234, 18'd567);
        tick();
        checks++; if (ra2 !== 16'd24464) begin errors++; $display("FAIL outonly_ra2: got %0d expected 24464", ra2); end
        checks++; if (rb2 !== 36'd699678) begin errors++; $display("FAIL outonly_rb2: got %0d expected 699678", rb2); end
        // output stage disabled: value held despite new operands
        ena = 3'b011;
        set_ops(18'd7, 18'd7, 18'd7, 18'd7);
        tick();
        checks++; if (ra2 !== 16'd24464) begin errors++; $display("FAIL outonly_hold: got %0d expected 24464", ra2); end
        ena = 3'b111;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            set_ops(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
            ena = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            if ($urandom_range(0, 39) == 0) begin
                #2;
                clr = 2'($urandom_range(1, 3));
                model_clear();
                #1;
                checks++; if (ra !== 36'(s4p[0])) begin errors++; $display("FAIL rnd_clr_ra n%0d: got %0d expected %0d", n, ra, s4p[0]); end
                tick();
                clr = 2'b00;
            end else begin
                tick();
            end
            checks++; if (ra !== 36'(s4p[0])) begin errors++; $display("FAIL rnd_ra n%0d: got %0d expected %0d", n, ra, s4p[0]); end
            checks++; if (rb !== 36'(s4p[1])) begin errors++; $display("FAIL rnd_rb n%0d: got %0d expected %0d", n, rb, s4p[1]); end
            checks++; if (ra2 !== 16'(low_bits(o2p[0], 16))) begin errors++; $display("FAIL rnd_ra2 n%0d: got %0d expected %0d", n, ra2, low_bits(o2p[0], 16)); end
            checks++; if (rb2 !== 36'(o2p[1])) begin errors++; $display("FAIL rnd_rb2 n%0d: got %0d expected %0d", n, rb2, o2p[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max();
        test_back_to_back();
        test_stall();
        test_clear_mid();
        test_out_only();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
